// File: rtl/voxel_pkg.sv
// voxel_pkg
// Shared definitions for the voxel memory write path.
//   VOX_ADDR_W / VOX_DATA_W : default voxel memory address / word widths
//   VOX_FIFO_DEPTH          : default host write queue depth
//   arb_state_t             : write arbiter FSM states
//   vox_wr_req_t            : one write request {addr, data} at the default widths;
//                             the host queue stores entries in this same bit layout.
package voxel_pkg;

    localparam int VOX_ADDR_W     = 18;
    localparam int VOX_DATA_W     = 64;
    localparam int VOX_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ARB_OPEN   = 2'd0,
        ARB_FENCED = 2'd1,
        ARB_FLUSH  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [VOX_ADDR_W-1:0] addr;
        logic [VOX_DATA_W-1:0] data;
    } vox_wr_req_t;

endpackage

// File: rtl/voxel_wr_fifo.sv
// voxel_wr_fifo
// Synchronous FIFO for queued host writes. The head entry is visible
// combinationally so the arbiter can pop and issue it in the same cycle.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears contents)
//   push, push_data  : enqueue (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   head             : current head entry
//   count            : number of stored entries
//   full, empty      : status flags derived from count
module voxel_wr_fifo #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = storage[rd_ptr];

    // Data storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/voxel_write_arbiter.sv
// voxel_write_arbiter
// Sequences writes into the voxel geometry memory from the world generator
// (always wins, no backpressure) and a queued host/debug write path.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   gen_wr_en/addr/data                   : generator write, issued immediately
//   host_wr_valid/ready/addr/data         : host write into the queue
//   fence_en, core_busy                   : hold host drain while the core renders
//   flush_req, flush_done                 : drain-everything handshake
//   mem_write_en/addr/data                : registered memory write port
//   fifo_count, idle, wr_count            : status and write statistics
module voxel_write_arbiter
    import voxel_pkg::*;
#(
    parameter int ADDR_W     = VOX_ADDR_W,
    parameter int DATA_W     = VOX_DATA_W,
    parameter int FIFO_DEPTH = VOX_FIFO_DEPTH,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        gen_wr_en,
    input  logic [ADDR_W-1:0]           gen_wr_addr,
    input  logic [DATA_W-1:0]           gen_wr_data,
    input  logic                        host_wr_valid,
    output logic                        host_wr_ready,
    input  logic [ADDR_W-1:0]           host_wr_addr,
    input  logic [DATA_W-1:0]           host_wr_data,
    input  logic                        fence_en,
    input  logic                        core_busy,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic                        mem_write_en,
    output logic [ADDR_W-1:0]           mem_write_addr,
    output logic [DATA_W-1:0]           mem_write_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        idle,
    output logic [CNT_W-1:0]            wr_count
);

    arb_state_t                 state;
    arb_state_t                 state_next;
    logic                       flush_done_next;
    logic                       host_push;
    logic                       host_pop;
    logic                       drain_ok;
    logic                       fence_hold;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ADDR_W+DATA_W-1:0]   fifo_head;

    voxel_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (host_push),
        .push_data ({host_wr_addr, host_wr_data}),
        .pop       (host_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready uses the pre-pop count, so a full queue refuses a push even in
    // a cycle where it also pops. Pushes are frozen while flushing.
    assign host_wr_ready = !fifo_full && (state != ARB_FLUSH);
    assign host_push     = host_wr_valid && host_wr_ready;
    assign fence_hold    = fence_en && core_busy;
    assign drain_ok      = (state != ARB_FENCED);
    assign host_pop      = !gen_wr_en && !fifo_empty && drain_ok;
    assign idle          = (fifo_count == '0) && !mem_write_en;

    // A flush request that finds nothing queued (and nothing arriving this
    // cycle) completes immediately without entering FLUSH. In FLUSH no pushes
    // are accepted, so an empty queue means the final pop has already been
    // registered onto the memory port; flush_done lands one cycle after it.
    always_comb begin
        state_next      = state;
        flush_done_next = 1'b0;
        case (state)
            ARB_OPEN, ARB_FENCED: begin
                if (flush_req && fifo_empty && !host_push) begin
                    flush_done_next = 1'b1;
                    state_next      = fence_hold ? ARB_FENCED : ARB_OPEN;
                end else if (flush_req) begin
                    state_next = ARB_FLUSH;
                end else if (fence_hold) begin
                    state_next = ARB_FENCED;
                end else begin
                    state_next = ARB_OPEN;
                end
            end
            ARB_FLUSH: begin
                if (fifo_empty) begin
                    flush_done_next = 1'b1;
                    state_next      = ARB_OPEN;
                end
            end
            default: state_next = ARB_OPEN;
        endcase
    end

    // Registered memory port: address/data hold their last value between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_OPEN;
            flush_done     <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            wr_count       <= '0;
        end else begin
            state        <= state_next;
            flush_done   <= flush_done_next;
            mem_write_en <= gen_wr_en || host_pop;
            if (gen_wr_en) begin
                mem_write_addr <= gen_wr_addr;
                mem_write_data <= gen_wr_data;
            end else if (host_pop) begin
                mem_write_addr <= fifo_head[DATA_W +: ADDR_W];
                mem_write_data <= fifo_head[DATA_W-1:0];
            end
            if (mem_write_en) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_voxel_write_arbiter.sv
// tb_voxel_write_arbiter
// Directed scenario bench for voxel_write_arbiter. Each scenario task drives
// its own stimulus and compares observed outputs against hand-computed values.
module tb_voxel_write_arbiter;
    import voxel_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_wr_en;
    logic [17:0] gen_wr_addr;
    logic [63:0] gen_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [17:0] host_wr_addr;
    logic [63:0] host_wr_data;
    logic        fence_en;
    logic        core_busy;
    logic        flush_req;
    logic        flush_done;
    logic        mem_write_en;
    logic [17:0] mem_write_addr;
    logic [63:0] mem_write_data;
    logic [3:0]  fifo_count;
    logic        idle;
    logic [31:0] wr_count;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    vox_wr_req_t wlog [$];
    int          wcyc [$];
    int          fdlog [$];

    voxel_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .gen_wr_en      (gen_wr_en),
        .gen_wr_addr    (gen_wr_addr),
        .gen_wr_data    (gen_wr_data),
        .host_wr_valid  (host_wr_valid),
        .host_wr_ready  (host_wr_ready),
        .host_wr_addr   (host_wr_addr),
        .host_wr_data   (host_wr_data),
        .fence_en       (fence_en),
        .core_busy      (core_busy),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .fifo_count     (fifo_count),
        .idle           (idle),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every memory write and flush_done pulse mid-cycle.
    always @(negedge clk) begin
        if (mem_write_en === 1'b1) begin
            wlog.push_back(vox_wr_req_t'({mem_write_addr, mem_write_data}));
            wcyc.push_back(cyc);
        end
        if (flush_done === 1'b1) begin
            fdlog.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog.delete();
        wcyc.delete();
        fdlog.delete();
    endtask

    // Queue n host writes at consecutive cycles: addr base+i, data dbase+i.
    task automatic push_n(input int n, input int base, input int dbase);
        for (int i = 0; i < n; i++) begin
            host_wr_valid = 1'b1;
            host_wr_addr  = 18'(base + i);
            host_wr_data  = 64'(dbase + i);
            tick();
        end
        host_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (mem_write_en !== 1'b0) $display("[TB] FAIL reset_wen: got %b expected 0", mem_write_en); else passes++;
        checks++; if (mem_write_addr !== 18'd0) $display("[TB] FAIL reset_addr: got %h expected 0", mem_write_addr); else passes++;
        checks++; if (mem_write_data !== 64'd0) $display("[TB] FAIL reset_data: got %h expected 0", mem_write_data); else passes++;
        checks++; if (fifo_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); else passes++;
        checks++; if (wr_count !== 32'd0) $display("[TB] FAIL reset_wr_count: got %0d expected 0", wr_count); else passes++;
        checks++; if (host_wr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", host_wr_ready); else passes++;
        checks++; if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %b expected 1", idle); else passes++;
        checks++; if (flush_done !== 1'b0) $display("[TB] FAIL reset_flush_done: got %b expected 0", flush_done); else passes++;
    endtask

    task automatic test_basic_drain();
        int acc;
        vox_wr_req_t exp_q [3];
        exp_q[0] = '{addr: 18'd5, data: 64'hA};
        exp_q[1] = '{addr: 18'd6, data: 64'hB};
        exp_q[2] = '{addr: 18'd7, data: 64'hC};
        clear_logs();
        host_wr_valid = 1'b1; host_wr_addr = 18'd5; host_wr_data = 64'hA;
        tick();
        acc = cyc;
        host_wr_addr = 18'd6; host_wr_data = 64'hB;
        tick();
        host_wr_addr = 18'd7; host_wr_data = 64'hC;
        tick();
        host_wr_valid = 1'b0;
        repeat (6) tick();
        checks++; if (wlog.size() != 3) $display("[TB] FAIL basic_nwrites: got %0d expected 3", wlog.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wlog.size()) $display("[TB] FAIL basic_write%0d: got none expected %h", i, exp_q[i]);
            else if (wlog[i] !== exp_q[i] || wcyc[i] != acc + 1 + i)
                $display("[TB] FAIL basic_write%0d: got %h at cycle %0d expected %h at cycle %0d", i, wlog[i], wcyc[i], exp_q[i], acc + 1 + i);
            else passes++;
        end
        checks++; if (wr_count !== 32'd3) $display("[TB] FAIL basic_wr_count: got %0d expected 3", wr_count); else passes++;
        checks++; if (idle !== 1'b1) $display("[TB] FAIL basic_idle: got %b expected 1", idle); else passes++;
    endtask

    task automatic test_gen_priority();
        vox_wr_req_t exp_q [6];
        for (int i = 0; i < 4; i++) exp_q[i] = '{addr: 18'(100 + i), data: 64'(32'h1000 + i)};
        exp_q[4] = '{addr: 18'd10, data: 64'h10};
        exp_q[5] = '{addr: 18'd11, data: 64'h11};
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            gen_wr_en   = 1'b1;
            gen_wr_addr = 18'(100 + i);
            gen_wr_data = 64'(32'h1000 + i);
            host_wr_valid = (i < 2);
            host_wr_addr  = 18'(10 + i);
            host_wr_data  = 64'(16 + i);
            tick();
        end
        host_wr_valid = 1'b0;
        checks++; if (fifo_count !== 4'd2) $display("[TB] FAIL gen_queued: got %0d expected 2", fifo_count); else passes++;
        gen_wr_en = 1'b0;
        repeat (6) tick();
        checks++; if (wlog.size() != 6) $display("[TB] FAIL gen_nwrites: got %0d expected 6", wlog.size()); else passes++;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= wlog.size()) $display("[TB] FAIL gen_write%0d: got none expected %h", i, exp_q[i]);
            else if (wlog[i] !== exp_q[i] || wcyc[i] != wcyc[0] + i)
                $display("[TB] FAIL gen_write%0d: got %h at cycle %0d expected %h at cycle %0d", i, wlog[i], wcyc[i], exp_q[i], wcyc[0] + i);
            else passes++;
        end
        checks++; if (wr_count !== 32'd9) $display("[TB] FAIL gen_wr_count: got %0d expected 9", wr_count); else passes++;
    endtask

    task automatic test_fence();
        clear_logs();
        fence_en = 1'b1; core_busy = 1'b1;
        tick();
        push_n(8, 20, 32'h200);
        repeat (3) tick();
        checks++; if (host_wr_ready !== 1'b0) $display("[TB] FAIL fence_ready: got %b expected 0", host_wr_ready); else passes++;
        checks++; if (fifo_count !== 4'd8) $display("[TB] FAIL fence_count: got %0d expected 8", fifo_count); else passes++;
        checks++; if (wlog.size() != 0) $display("[TB] FAIL fence_held: got %0d writes expected 0", wlog.size()); else passes++;
        core_busy = 1'b0;
        repeat (12) tick();
        checks++; if (wlog.size() != 8) $display("[TB] FAIL fence_nwrites: got %0d expected 8", wlog.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= wlog.size()) $display("[TB] FAIL fence_write%0d: got none expected addr %0d", i, 20 + i);
            else if (wlog[i].addr !== 18'(20 + i) || wlog[i].data !== 64'(32'h200 + i) || wcyc[i] != wcyc[0] + i)
                $display("[TB] FAIL fence_write%0d: got %h at cycle %0d expected addr %0d at cycle %0d", i, wlog[i], wcyc[i], 20 + i, wcyc[0] + i);
            else passes++;
        end
        checks++; if (wr_count !== 32'd17) $display("[TB] FAIL fence_wr_count: got %0d expected 17", wr_count); else passes++;
    endtask

    task automatic test_flush();
        core_busy = 1'b1;
        tick();
        push_n(4, 30, 32'h300);
        tick();
        clear_logs();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        checks++; if (host_wr_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", host_wr_ready); else passes++;
        host_wr_valid = 1'b1; host_wr_addr = 18'h3F; host_wr_data = 64'hDEAD;
        tick();
        host_wr_valid = 1'b0;
        repeat (8) tick();
        checks++; if (wlog.size() != 4) $display("[TB] FAIL flush_nwrites: got %0d expected 4", wlog.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wlog.size()) $display("[TB] FAIL flush_write%0d: got none expected addr %0d", i, 30 + i);
            else if (wlog[i].addr !== 18'(30 + i) || wlog[i].data !== 64'(32'h300 + i))
                $display("[TB] FAIL flush_write%0d: got %h expected addr %0d", i, wlog[i], 30 + i);
            else passes++;
        end
        checks++; if (fdlog.size() != 1) $display("[TB] FAIL flush_done_pulses: got %0d expected 1", fdlog.size()); else passes++;
        checks++;
        if (fdlog.size() < 1 || wcyc.size() < 4) $display("[TB] FAIL flush_done_timing: got no pulse or writes expected one pulse");
        else if (fdlog[0] != wcyc[3] + 1) $display("[TB] FAIL flush_done_timing: got cycle %0d expected %0d", fdlog[0], wcyc[3] + 1);
        else passes++;
        fence_en = 1'b0; core_busy = 1'b0;
        tick();
        checks++; if (wr_count !== 32'd21) $display("[TB] FAIL flush_wr_count: got %0d expected 21", wr_count); else passes++;
    endtask

    task automatic test_flush_empty();
        clear_logs();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        checks++; if (flush_done !== 1'b1) $display("[TB] FAIL flush_empty_done: got %b expected 1", flush_done); else passes++;
        tick();
        checks++; if (flush_done !== 1'b0) $display("[TB] FAIL flush_empty_once: got %b expected 0", flush_done); else passes++;
        checks++; if (host_wr_ready !== 1'b1) $display("[TB] FAIL flush_empty_ready: got %b expected 1", host_wr_ready); else passes++;
    endtask

    task automatic test_full_push_pop();
        fence_en = 1'b1; core_busy = 1'b1;
        tick();
        push_n(8, 40, 32'h400);
        clear_logs();
        core_busy = 1'b0;
        tick();
        host_wr_valid = 1'b1; host_wr_addr = 18'h3BAD; host_wr_data = 64'hBAD;
        #1;
        checks++; if (host_wr_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b expected 0", host_wr_ready); else passes++;
        checks++; if (fifo_count !== 4'd8) $display("[TB] FAIL full_count_before: got %0d expected 8", fifo_count); else passes++;
        tick();
        host_wr_valid = 1'b0;
        checks++; if (fifo_count !== 4'd7) $display("[TB] FAIL full_count_after: got %0d expected 7", fifo_count); else passes++;
        fence_en = 1'b0;
        repeat (12) tick();
        checks++; if (wlog.size() != 8) $display("[TB] FAIL full_nwrites: got %0d expected 8", wlog.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= wlog.size()) $display("[TB] FAIL full_write%0d: got none expected addr %0d", i, 40 + i);
            else if (wlog[i].addr !== 18'(40 + i) || wlog[i].data !== 64'(32'h400 + i))
                $display("[TB] FAIL full_write%0d: got %h expected addr %0d", i, wlog[i], 40 + i);
            else passes++;
        end
        checks++; if (fifo_count !== 4'd0) $display("[TB] FAIL full_drained: got %0d expected 0", fifo_count); else passes++;
    endtask

    task automatic test_reset_mid_drain();
        fence_en = 1'b1; core_busy = 1'b1;
        tick();
        push_n(5, 50, 32'h500);
        fence_en = 1'b0; core_busy = 1'b0;
        tick();
        tick();
        checks++; if (mem_write_en !== 1'b1) $display("[TB] FAIL middrain_active: got %b expected 1", mem_write_en); else passes++;
        checks++; if (fifo_count !== 4'd4) $display("[TB] FAIL middrain_count: got %0d expected 4", fifo_count); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        checks++; if (mem_write_en !== 1'b0) $display("[TB] FAIL rst_drain_wen: got %b expected 0", mem_write_en); else passes++;
        checks++; if (fifo_count !== 4'd0) $display("[TB] FAIL rst_drain_count: got %0d expected 0", fifo_count); else passes++;
        checks++; if (wr_count !== 32'd0) $display("[TB] FAIL rst_drain_wr_count: got %0d expected 0", wr_count); else passes++;
        repeat (10) tick();
        checks++; if (wlog.size() != 0) $display("[TB] FAIL rst_drain_quiet: got %0d writes expected 0", wlog.size()); else passes++;
        checks++; if (wr_count !== 32'd0) $display("[TB] FAIL rst_drain_wr_count_hold: got %0d expected 0", wr_count); else passes++;
        checks++; if (idle !== 1'b1) $display("[TB] FAIL rst_drain_idle: got %b expected 1", idle); else passes++;
    endtask

    initial begin
        rst           = 1'b1;
        gen_wr_en     = 1'b0;
        gen_wr_addr   = '0;
        gen_wr_data   = '0;
        host_wr_valid = 1'b0;
        host_wr_addr  = '0;
        host_wr_data  = '0;
        fence_en      = 1'b0;
        core_busy     = 1'b0;
        flush_req     = 1'b0;
        test_reset();
        test_basic_drain();
        test_gen_priority();
        test_fence();
        test_flush();
        test_flush_empty();
        test_full_push_pop();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
